// File: rtl/nes_video_timing.sv
// nes_video_timing: 640x480 raster timing with a 2x-scaled, horizontally centred NES window.
// Reads the framebuffer during the window and emits aligned, fully registered RGB/hsync/vsync/vde.
module nes_video_timing #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   WIN_X0    = 64
) (
  input  logic        clkx1in,
  input  logic        reset_n,
  input  logic [23:0] border_rgb,
  output logic        pix_rd_en,
  output logic [7:0]  pix_rd_x,
  output logic [7:0]  pix_rd_y,
  input  logic [23:0] pix_rd_data,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        hsync,
  output logic        vsync,
  output logic        vde,
  output logic        frame_start
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] HS0    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS0    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] WX0    = 10'(WIN_X0);
  localparam logic [9:0] WX1    = 10'(WIN_X0 + 512);

  if (WIN_X0 + 512 > H_ACTIVE || V_ACTIVE != 480) begin : g_bad_params
    $error("nes_video_timing: NES window does not fit the active raster");
  end

  logic [9:0] hc, vc;
  logic       act, win, hs, vs;
  logic       act1, win1, hs1, vs1;

  always_ff @(posedge clkx1in or negedge reset_n)
    if (!reset_n) begin
      hc          <= H_LAST;
      vc          <= V_LAST;
      frame_start <= 1'b0;
    end else begin
      hc          <= hc == H_LAST ? '0 : hc + 10'd1;
      if (hc == H_LAST) vc <= vc == V_LAST ? '0 : vc + 10'd1;
      frame_start <= hc == H_LAST && vc == V_LAST;
    end

  assign act       = hc < HA && vc < VA;
  assign win       = act && hc >= WX0 && hc < WX1;
  assign hs        = hc >= HS0 && hc < HS1;
  assign vs        = vc >= VS0 && vc < VS1;
  assign pix_rd_en = win;
  assign pix_rd_x  = win ? 8'((hc - WX0) >> 1) : '0;
  assign pix_rd_y  = win ? 8'(vc >> 1) : '0;

  // Decode is delayed one stage so it lines up with the synchronous RAM read data
  always_ff @(posedge clkx1in or negedge reset_n)
    if (!reset_n) begin
      {act1, win1, hs1, vs1}           <= '0;
      vde                              <= 1'b0;
      hsync                            <= ~HSYNC_POL;
      vsync                            <= ~VSYNC_POL;
      {red_out, green_out, blue_out}   <= '0;
    end else begin
      {act1, win1, hs1, vs1}           <= {act, win, hs, vs};
      vde                              <= act1;
      hsync                            <= hs1 ? HSYNC_POL : ~HSYNC_POL;
      vsync                            <= vs1 ? VSYNC_POL : ~VSYNC_POL;
      {red_out, green_out, blue_out}   <= win1 ? pix_rd_data : act1 ? border_rgb : '0;
    end
endmodule
